// File: rtl/trivium_pkg.sv
// Shared constants and the receive-side state encoding for the Trivium stream path.
package trivium_pkg;

  localparam int TRIVIUM_STATE_BITS = 288;
  localparam int TRIVIUM_WARMUP     = 4 * TRIVIUM_STATE_BITS;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_CNT_W          = 11;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    FILL   = 2'd1,
    HOLD   = 2'd2
  } dec_state_e;

endpackage

// File: rtl/trivium_stream_decrypt_ks_packer.sv
// Packs serial keystream bits LSB-first into a word; flags a full word until it is consumed.
module ks_packer
  import trivium_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              consume,
  output logic [DATA_W-1:0] word,
  output logic              last,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    last   = shift_en && (cnt_q == LAST_IDX);
    if (consume) done_d = 1'b0;
    if (shift_en) begin
      sr_d[cnt_q] = bit_in;
      cnt_d       = last ? '0 : cnt_q + 1'b1;
      if (last) done_d = 1'b1;
    end
  end

  assign word = sr_q;
  assign done = done_q;

endmodule

// File: rtl/trivium_stream_decrypt.sv
// Throttles the Trivium core, discards its warm-up output, and XORs packed keystream
// words onto a ciphertext valid/ready stream.
module trivium_stream_decrypt
  import trivium_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WARMUP_CYCLES = TRIVIUM_WARMUP,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ks_bit,
  output logic              ks_en,
  input  logic [DATA_W-1:0] ct_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  output logic [DATA_W-1:0] pt_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              warm_done
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);

  dec_state_e        state_q, state_d;
  logic              ks_en_q, ks_en_d;
  logic [CNT_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic              warm_done_q, warm_done_d;
  logic [DATA_W-1:0] pt_data_q, pt_data_d;
  logic              pt_valid_q, pt_valid_d;

  logic              accept;
  logic              ks_shift;
  logic              ks_last;
  logic              ks_done;
  logic [DATA_W-1:0] ks_word;

  ks_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (ks_shift),
    .bit_in   (ks_bit),
    .consume  (accept),
    .word     (ks_word),
    .last     (ks_last),
    .done     (ks_done)
  );

  // ks_en is registered so it reads 0 throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WARMUP;
      ks_en_q     <= 1'b0;
      warm_cnt_q  <= '0;
      warm_done_q <= 1'b0;
      pt_data_q   <= '0;
      pt_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ks_en_q     <= ks_en_d;
      warm_cnt_q  <= warm_cnt_d;
      warm_done_q <= warm_done_d;
      pt_data_q   <= pt_data_d;
      pt_valid_q  <= pt_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARMUP:  if (ks_en_q && (warm_cnt_q == WARM_LAST)) state_d = FILL;
      FILL:    if (ks_last) state_d = HOLD;
      HOLD:    if (accept) state_d = FILL;
      default: state_d = WARMUP;
    endcase
  end

  always_comb begin
    ct_ready    = (state_q == HOLD) && ks_done && (!pt_valid_q || pt_ready);
    accept      = ct_valid && ct_ready;
    ks_shift    = (state_q == FILL) && ks_en_q;
    ks_en_d     = (state_d != HOLD);
    warm_cnt_d  = warm_cnt_q;
    warm_done_d = warm_done_q;
    if ((state_q == WARMUP) && ks_en_q) begin
      if (warm_cnt_q == WARM_LAST) warm_done_d = 1'b1;
      else                         warm_cnt_d  = warm_cnt_q + 1'b1;
    end
    pt_data_d  = pt_data_q;
    pt_valid_d = pt_valid_q;
    if (accept) begin
      pt_data_d  = ct_data ^ ks_word;
      pt_valid_d = 1'b1;
    end else if (pt_ready) begin
      pt_valid_d = 1'b0;
    end
  end

  assign ks_en     = ks_en_q;
  assign pt_data   = pt_data_q;
  assign pt_valid  = pt_valid_q;
  assign warm_done = warm_done_q;

endmodule
